clk_div_monitor: RTL and testbench

Receive-side checker for the integer clock divider. It samples a divided clock in the `clk` domain and measures the period and high time in `clk` cycles. It reports the recovered division ratio, declares lock after consistent periods, and flags stalled or malformed (bad duty) divided clocks. It sits next to the divider's `o_div_clk` output and is used for in-system self-check and for bench scoreboarding.

---
 rtl/clk_div_monitor.sv | 120 ++++++++++++
 tb/tb_clk_div_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Receive-side checker for the integer clock divider: measures period and
// high time of a clk-synchronous divided clock, reports lock, stall and duty faults.
module clk_div_monitor #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             i_div_clk,
    output logic [WIDTH-1:0] o_ratio,
    output logic [WIDTH-1:0] o_high_cnt,
    output logic             o_update,
    output logic             o_valid,
    output logic             o_stall,
    output logic             o_duty_err
);

    localparam int MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] PMAX   = '1;
    localparam logic [MW-1:0]    LOCK_M = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        MEAS
    } state_t;

    state_t           state;
    logic             s;
    logic             s_d;
    logic             rise;
    logic [WIDTH-1:0] per_cnt;
    logic [WIDTH-1:0] hi_cnt;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    match_nxt;
    logic [WIDTH-1:0] h_lo;
    logic [WIDTH-1:0] h_hi;
    logic             duty_ok;

    assign rise = s & ~s_d;

    // o_ratio doubles as the previous captured period; match_cnt==0 marks
    // that no capture has happened since SYNC.
    always_comb begin
        match_nxt = MW'(1);
        if (match_cnt != '0 && per_cnt == o_ratio) begin
            match_nxt = (match_cnt == LOCK_M) ? match_cnt : match_cnt + 1'b1;
        end
        h_lo    = per_cnt >> 1;
        h_hi    = h_lo + {{(WIDTH-1){1'b0}}, per_cnt[0]};
        duty_ok = (hi_cnt == h_lo) || (hi_cnt == h_hi);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            s          <= 1'b0;
            s_d        <= 1'b0;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            match_cnt  <= '0;
            o_ratio    <= '0;
            o_high_cnt <= '0;
            o_update   <= 1'b0;
            o_valid    <= 1'b0;
            o_stall    <= 1'b0;
            o_duty_err <= 1'b0;
        end else begin
            s        <= i_div_clk;
            s_d      <= s;
            o_update <= 1'b0;
            if (!enable) begin
                state      <= IDLE;
                per_cnt    <= '0;
                hi_cnt     <= '0;
                match_cnt  <= '0;
                o_ratio    <= '0;
                o_high_cnt <= '0;
                o_valid    <= 1'b0;
                o_stall    <= 1'b0;
                o_duty_err <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: state <= SYNC;
                    SYNC: begin
                        if (rise) begin
                            per_cnt <= WIDTH'(1);
                            hi_cnt  <= WIDTH'(1);
                            state   <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            o_ratio    <= per_cnt;
                            o_high_cnt <= hi_cnt;
                            o_update   <= 1'b1;
                            match_cnt  <= match_nxt;
                            o_valid    <= (match_nxt >= LOCK_M);
                            o_duty_err <= ~duty_ok;
                            o_stall    <= 1'b0;
                            per_cnt    <= WIDTH'(1);
                            hi_cnt     <= WIDTH'(1);
                        end else if (per_cnt == PMAX) begin
                            o_stall   <= 1'b1;
                            o_valid   <= 1'b0;
                            match_cnt <= '0;
                            state     <= SYNC;
                        end else begin
                            per_cnt <= per_cnt + 1'b1;
                            if (s) hi_cnt <= hi_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized bench for clk_div_monitor against a rise-list reference model.
module tb_clk_div_monitor;

    localparam int W  = 8;
    localparam int LC = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         i_div_clk = 1'b0;
    logic [W-1:0] o_ratio;
    logic [W-1:0] o_high_cnt;
    logic         o_update;
    logic         o_valid;
    logic         o_stall;
    logic         o_duty_err;

    clk_div_monitor #(.WIDTH(W), .LOCK_COUNT(LC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .i_div_clk  (i_div_clk),
        .o_ratio    (o_ratio),
        .o_high_cnt (o_high_cnt),
        .o_update   (o_update),
        .o_valid    (o_valid),
        .o_stall    (o_stall),
        .o_duty_err (o_duty_err)
    );

    always #10 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    bit hist[$];
    bit enh[$];
    int periods[$];
    bit in_meas;
    int last_rise;
    int e_ratio, e_high;
    bit e_upd, e_val, e_stall, e_duty;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs != exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic void model_clear();
        in_meas   = 0;
        last_rise = 0;
        periods.delete();
        e_ratio = 0;
        e_high  = 0;
        e_upd   = 0;
        e_val   = 0;
        e_stall = 0;
        e_duty  = 0;
    endfunction

    // Outputs seen after edge n+2 reflect the sample driven in cycle n.
    function automatic void model_idx(input int n);
        bit prev;
        bit rise;
        int p, h, run;
        prev  = (n > 0) ? hist[n-1] : 1'b0;
        rise  = hist[n] && !prev;
        e_upd = 0;
        if (rise) begin
            if (in_meas) begin
                p = n - last_rise;
                h = 0;
                for (int i = last_rise; i < n; i++) h += int'(hist[i]);
                periods.push_back(p);
                if (periods.size() > 8) void'(periods.pop_front());
                run = 0;
                for (int i = periods.size() - 1; i >= 0; i--) begin
                    if (periods[i] != p) break;
                    run++;
                end
                e_ratio = p;
                e_high  = h;
                e_upd   = 1;
                e_stall = 0;
                e_val   = (run >= LC);
                e_duty  = (2*h - p > 1) || (p - 2*h > 1);
            end
            in_meas   = 1;
            last_rise = n;
        end else if (in_meas && (n - last_rise) == (1 << W) - 1) begin
            e_stall = 1;
            e_val   = 0;
            in_meas = 0;
            periods.delete();
        end
    endfunction

    task automatic step(input bit w, input bit en, input bit rst);
        @(posedge clk);
        if (cyc >= 2) model_idx(cyc - 2);
        if (cyc >= 1 && !enh[cyc-1]) model_clear();
        #1;
        i_div_clk = w;
        enable    = en;
        hist.push_back(w);
        enh.push_back(en);
        cyc++;
        if (rst) begin
            reset_n = 1'b0;
            model_clear();
            #5 reset_n = 1'b1;
        end
        @(negedge clk);
        chk("ratio",  int'(o_ratio),    e_ratio);
        chk("high",   int'(o_high_cnt), e_high);
        chk("update", int'(o_update),   int'(e_upd));
        chk("valid",  int'(o_valid),    int'(e_val));
        chk("stall",  int'(o_stall),    int'(e_stall));
        chk("duty",   int'(o_duty_err), int'(e_duty));
    endtask

    task automatic run_div(input int n, input int h, input int cnt);
        int hh;
        for (int k = 0; k < cnt; k++) begin
            hh = (h > 0) ? h : n / 2 + ((n % 2 == 1) ? int'($urandom_range(0, 1)) : 0);
            for (int i = 0; i < n; i++) step(i < hh, 1'b1, 1'b0);
        end
    endtask

    task automatic do_reset();
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic en_drop(input int off_len);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (off_len) step(1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int n, h, sel;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ratio", int'(o_ratio),    0);
        chk("rst_high",  int'(o_high_cnt), 0);
        chk("rst_upd",   int'(o_update),   0);
        chk("rst_valid", int'(o_valid),    0);
        chk("rst_stall", int'(o_stall),    0);
        chk("rst_duty",  int'(o_duty_err), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) step(1'b0, 1'b1, 1'b0);

        run_div(2, 1, 12);
        chk("div2_ratio", int'(o_ratio), 2);
        chk("div2_valid", int'(o_valid), 1);

        for (int d = 3; d <= 5; d++) begin
            do_reset();
            run_div(d, 0, 8);
            chk("divn_ratio", int'(o_ratio), d);
            chk("divn_valid", int'(o_valid), 1);
        end

        run_div(4, 2, 8);
        run_div(6, 3, 6);
        chk("sw_ratio", int'(o_ratio), 6);

        repeat (300) step(1'b0, 1'b1, 1'b0);
        chk("stall_set",   int'(o_stall), 1);
        chk("stall_valid", int'(o_valid), 0);
        run_div(2, 1, 6);
        chk("stall_clr", int'(o_stall), 0);

        run_div(255, 127, 3);
        chk("p255_ratio", int'(o_ratio), 255);
        chk("p255_stall", int'(o_stall), 0);
        repeat (130) step(1'b0, 1'b1, 1'b0);
        chk("p255_stall_gap", int'(o_stall), 1);

        run_div(6, 1, 4);
        chk("bad_high", int'(o_high_cnt), 1);
        chk("bad_duty", int'(o_duty_err), 1);

        run_div(3, 1, 6);
        chk("pre_drop_valid", int'(o_valid), 1);
        en_drop(3);
        run_div(3, 1, 4);
        chk("relock_valid", int'(o_valid), 1);

        repeat (40) begin
            n   = $urandom_range(2, 30);
            h   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : 0;
            run_div(n, h, $urandom_range(1, 5));
            sel = $urandom_range(0, 19);
            if (sel == 0) repeat ($urandom_range(2, 280)) step(1'b0, 1'b1, 1'b0);
            else if (sel == 1) en_drop($urandom_range(1, 4));
            else if (sel == 2) do_reset();
        end

        repeat (3) step(1'b0, 1'b1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
